// File: rtl/wb_unit.sv
// Writeback unit: arbitrates ALU/LSU results onto the register-file write port and
// tracks per-register pending writes. Define WB_RR_EN for round-robin contention (default: LSU priority).
module wb_unit #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [2:0]           issue_rd,
  input  logic [2:0]           issue_rs1,
  input  logic [2:0]           issue_rs2,
  output logic                 issue_stall,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [2:0]           alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [2:0]           lsu_rd,
  input  logic [XLEN-1:0]      lsu_data,
  output logic                 rf_we,
  output logic [2:0]           rf_rd_idx,
  output logic [XLEN-1:0]      rf_rd_data,
  output logic [REG_COUNT-1:0] pending,
  output logic                 wb_err
);

  logic                 issue_accept;
  logic                 lsu_wins;
  logic                 grant;
  logic [2:0]           win_rd;
  logic [XLEN-1:0]      win_data;
  logic [REG_COUNT-1:0] pending_next;

  // x0 never hazards; an in-flight writeback still counts as pending (no bypass).
  always_comb begin
    issue_stall = issue_valid &&
                  ((issue_rs1 != 3'd0 && pending[issue_rs1]) ||
                   (issue_rs2 != 3'd0 && pending[issue_rs2]) ||
                   (issue_rd  != 3'd0 && pending[issue_rd]));
  end

  assign issue_accept = issue_valid && !issue_stall;

`ifdef WB_RR_EN
  logic last_grant_lsu;

  assign lsu_wins = !last_grant_lsu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_lsu <= 1'b0;
    end else if (grant) begin
      last_grant_lsu <= lsu_ready;
    end
  end
`else
  assign lsu_wins = 1'b1;
`endif

  always_comb begin
    alu_ready = alu_valid && !(lsu_valid && lsu_wins);
    lsu_ready = lsu_valid && !(alu_valid && !lsu_wins);
    grant     = alu_ready || lsu_ready;
    win_rd    = lsu_ready ? lsu_rd   : alu_rd;
    win_data  = lsu_ready ? lsu_data : alu_data;
  end

  // Issue set is applied after writeback clear so a same-edge collision leaves the bit set.
  always_comb begin
    pending_next = pending;
    if (rf_we) begin
      pending_next[rf_rd_idx] = 1'b0;
    end
    if (issue_accept && issue_rd != 3'd0) begin
      pending_next[issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_rd_idx  <= 3'd0;
      rf_rd_data <= '0;
      pending    <= '0;
      wb_err     <= 1'b0;
    end else begin
      rf_we   <= grant && (win_rd != 3'd0);
      pending <= pending_next;
      if (grant) begin
        rf_rd_idx  <= win_rd;
        rf_rd_data <= win_data;
      end
      if (grant && win_rd != 3'd0 && !pending[win_rd]) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: directed writebacks are queued as expected
// register-file writes and a negedge monitor matches them against rf_we.
module tb_wb_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            issue_valid;
  logic [2:0]      issue_rd, issue_rs1, issue_rs2;
  logic            issue_stall;
  logic            alu_valid, alu_ready;
  logic [2:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid, lsu_ready;
  logic [2:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            rf_we;
  logic [2:0]      rf_rd_idx;
  logic [XLEN-1:0] rf_rd_data;
  logic [7:0]      pending;
  logic            wb_err;

  int checks = 0;
  int failures = 0;
  logic [34:0] exp_q[$];
  logic [34:0] mon_exp;

  always #5 clk = ~clk;

  wb_unit #(.XLEN(XLEN), .REG_COUNT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_we(rf_we), .rf_rd_idx(rf_rd_idx), .rf_rd_data(rf_rd_data),
    .pending(pending), .wb_err(wb_err)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [2:0] ird, input logic [2:0] irs1,
                               input logic [2:0] irs2, input logic av, input logic [2:0] ard,
                               input logic [31:0] ad, input logic lv, input logic [2:0] lrd,
                               input logic [31:0] ld);
    issue_valid = iv;
    issue_rd    = ird;
    issue_rs1   = irs1;
    issue_rs2   = irs2;
    alu_valid   = av;
    alu_rd      = ard;
    alu_data    = ad;
    lsu_valid   = lv;
    lsu_rd      = lrd;
    lsu_data    = ld;
  endtask

  task automatic driveIdle();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic expectWrite(input logic [2:0] idx, input logic [31:0] data);
    exp_q.push_back({idx, data});
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic midCycle();
    @(negedge clk);
  endtask

  // Monitor: every register-file write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL rf_write_unexpected actual idx=%0d data=0x%0h expected none",
                 rf_rd_idx, rf_rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rf_rd_idx !== mon_exp[34:32] || rf_rd_data !== mon_exp[31:0]) begin
          failures++;
          $display("[TB] FAIL rf_write actual idx=%0d data=0x%0h expected idx=%0d data=0x%0h",
                   rf_rd_idx, rf_rd_data, mon_exp[34:32], mon_exp[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    driveIdle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    midCycle();
    checkOutput("reset_rf_we",      32'(rf_we),      32'd0);
    checkOutput("reset_rf_rd_idx",  32'(rf_rd_idx),  32'd0);
    checkOutput("reset_rf_rd_data", rf_rd_data,      32'd0);
    checkOutput("reset_pending",    32'(pending),    32'd0);
    checkOutput("reset_wb_err",     32'(wb_err),     32'd0);
    checkOutput("reset_stall",      32'(issue_stall), 32'd0);

    // Issue rd=3 sets pending[3]
    nextCycle();
    applyStimulus(1'b1, 3'd3, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    midCycle();
    checkOutput("issue3_stall", 32'(issue_stall), 32'd0);
    nextCycle();
    driveIdle();
    midCycle();
    checkOutput("issue3_pending", 32'(pending), 32'h08);

    // Single ALU result x3
    nextCycle();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd3, 32'hDEADBEEF, 1'b0, 3'd0, 32'd0);
    expectWrite(3'd3, 32'hDEADBEEF);
    midCycle();
    checkOutput("alu3_alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("alu3_lsu_ready", 32'(lsu_ready), 32'd0);
    nextCycle();
    driveIdle();
    midCycle();
    checkOutput("alu3_rf_we",       32'(rf_we),   32'd1);
    checkOutput("alu3_pending_n1",  32'(pending), 32'h08);
    nextCycle();
    midCycle();
    checkOutput("alu3_pending_n2",  32'(pending), 32'h00);
    checkOutput("alu3_rf_we_off",   32'(rf_we),   32'd0);
    checkOutput("alu3_wb_err",      32'(wb_err),  32'd0);

    // RAW / WAW hazards on x5
    nextCycle();
    applyStimulus(1'b1, 3'd5, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    midCycle();
    checkOutput("issue5_stall", 32'(issue_stall), 32'd0);
    nextCycle();
    driveIdle();
    midCycle();
    checkOutput("issue5_pending", 32'(pending), 32'h20);
    nextCycle();
    applyStimulus(1'b1, 3'd0, 3'd5, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    midCycle();
    checkOutput("raw5_stall", 32'(issue_stall), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    midCycle();
    checkOutput("x0_no_stall", 32'(issue_stall), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 3'd5, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    midCycle();
    checkOutput("waw5_stall", 32'(issue_stall), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 3'd0, 3'd5, 3'd0, 1'b1, 3'd5, 32'h55555555, 1'b0, 3'd0, 32'd0);
    expectWrite(3'd5, 32'h55555555);
    midCycle();
    checkOutput("raw5_stall_hs",  32'(issue_stall), 32'd1);
    checkOutput("alu5_alu_ready", 32'(alu_ready),   32'd1);
    nextCycle();
    applyStimulus(1'b1, 3'd0, 3'd5, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    midCycle();
    checkOutput("raw5_stall_inflight", 32'(issue_stall), 32'd1);
    checkOutput("alu5_rf_we",          32'(rf_we),       32'd1);
    nextCycle();
    midCycle();
    checkOutput("raw5_stall_released", 32'(issue_stall), 32'd0);
    nextCycle();
    driveIdle();
    midCycle();
    checkOutput("x5_pending_clear", 32'(pending), 32'h00);

    // Contention round 1: ALU x1 vs LSU x2
    nextCycle();
    applyStimulus(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 3'd2, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    nextCycle();
    driveIdle();
    midCycle();
    checkOutput("cont1_pending", 32'(pending), 32'h06);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd1, 32'h11111111, 1'b1, 3'd2, 32'h22222222);
    expectWrite(3'd2, 32'h22222222);
    midCycle();
    checkOutput("cont1_lsu_ready", 32'(lsu_ready), 32'd1);
    checkOutput("cont1_alu_ready", 32'(alu_ready), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd1, 32'h11111111, 1'b0, 3'd0, 32'd0);
    expectWrite(3'd1, 32'h11111111);
    midCycle();
    checkOutput("cont2_alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("cont2_lsu_ready", 32'(lsu_ready), 32'd0);
    nextCycle();
    driveIdle();
    repeat (2) nextCycle();
    midCycle();
    checkOutput("cont2_pending", 32'(pending), 32'h00);

    // Contention round 2: LSU wins again in both arbitration modes
    nextCycle();
    applyStimulus(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 3'd7, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd1, 32'hAAAA0001, 1'b1, 3'd7, 32'hBBBB0007);
    expectWrite(3'd7, 32'hBBBB0007);
    midCycle();
    checkOutput("cont3_pending",   32'(pending),   32'h82);
    checkOutput("cont3_lsu_ready", 32'(lsu_ready), 32'd1);
    checkOutput("cont3_alu_ready", 32'(alu_ready), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd1, 32'hAAAA0001, 1'b0, 3'd0, 32'd0);
    expectWrite(3'd1, 32'hAAAA0001);
    midCycle();
    checkOutput("cont4_alu_ready", 32'(alu_ready), 32'd1);
    nextCycle();
    driveIdle();
    repeat (2) nextCycle();
    midCycle();
    checkOutput("cont4_pending", 32'(pending), 32'h00);
    checkOutput("cont4_wb_err",  32'(wb_err),  32'd0);

    // rd=0 result is consumed and dropped
    nextCycle();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd0, 32'h12345678, 1'b0, 3'd0, 32'd0);
    midCycle();
    checkOutput("rd0_alu_ready", 32'(alu_ready), 32'd1);
    nextCycle();
    driveIdle();
    midCycle();
    checkOutput("rd0_rf_we",  32'(rf_we),  32'd0);
    checkOutput("rd0_wb_err", 32'(wb_err), 32'd0);

    // Result to non-pending x4 is written and flags a sticky error
    nextCycle();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b1, 3'd4, 32'h44444444);
    expectWrite(3'd4, 32'h44444444);
    midCycle();
    checkOutput("x4_lsu_ready", 32'(lsu_ready), 32'd1);
    nextCycle();
    driveIdle();
    midCycle();
    checkOutput("x4_wb_err", 32'(wb_err), 32'd1);
    nextCycle();
    midCycle();
    checkOutput("x4_wb_err_sticky", 32'(wb_err),  32'd1);
    checkOutput("x4_pending",       32'(pending), 32'h00);

    // Issue rd=6 on the same edge a writeback clears x6: set wins
    nextCycle();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd6, 32'h66666666, 1'b0, 3'd0, 32'd0);
    expectWrite(3'd6, 32'h66666666);
    nextCycle();
    applyStimulus(1'b1, 3'd6, 3'd0, 3'd0, 1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    midCycle();
    checkOutput("x6_rf_we",  32'(rf_we),       32'd1);
    checkOutput("x6_stall",  32'(issue_stall), 32'd0);
    nextCycle();
    driveIdle();
    midCycle();
    checkOutput("x6_set_wins", 32'(pending), 32'h40);

    // Async reset while a write is in flight
    nextCycle();
    applyStimulus(1'b0, 3'd0, 3'd0, 3'd0, 1'b1, 3'd3, 32'h33333333, 1'b0, 3'd0, 32'd0);
    nextCycle();
    driveIdle();
    checkOutput("rst_pre_rf_we", 32'(rf_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_rf_we",   32'(rf_we),   32'd0);
    checkOutput("rst_pending", 32'(pending), 32'h00);
    checkOutput("rst_wb_err",  32'(wb_err),  32'd0);
    #4 rst_n = 1'b1;
    nextCycle();
    midCycle();
    checkOutput("post_rst_rf_we",   32'(rf_we),   32'd0);
    checkOutput("post_rst_pending", 32'(pending), 32'h00);

    nextCycle();
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
